ysyx_22050039_fetch_queue: RTL and testbench

YSYX_22050039_FETCH_QUEUE -- requirements
Module: ysyx_22050039_fetch_queue

---
 rtl/ysyx_22050039_fetch_queue.sv | 101 ++++++++++
 tb/tb_ysyx_22050039_fetch_queue.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22050039_fetch_queue.sv
// Fetch queue between IFU and instruction memory: issues PCs, collects in-order
// responses into DEPTH slots, and presents them to the IDU in program order.
module ysyx_22050039_fetch_queue #(
    parameter int XLEN  = 64,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [XLEN-1:0] in_pc,
    output logic            in_ready,
    input  logic            flush,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [31:0]     out_inst
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [XLEN-1:0]  r_pc   [DEPTH];
    logic [31:0]      r_inst [DEPTH];
    logic [DEPTH-1:0] r_data_ok;
    logic [PW-1:0]    r_head;
    logic [PW-1:0]    r_tail;
    logic [PW-1:0]    r_wptr;
    logic [CW-1:0]    r_count;
    logic [CW-1:0]    r_pend;
    logic [CW-1:0]    r_drop;

    logic          w_credit;
    logic          w_fire;
    logic          w_pop;
    logic          w_owed;
    logic          w_rsp_drop;
    logic          w_rsp_wr;
    logic [CW:0]   w_used;

    // Responses return in order, so the oldest entry still waiting for data is
    // always r_wptr; r_pend counts allocated entries whose data has not arrived.
    always_comb begin
        w_used     = {1'b0, r_count} + {1'b0, r_drop};
        w_credit   = w_used < (CW + 1)'(DEPTH);
        w_owed     = (r_drop != '0) || (r_pend != '0);
        w_rsp_drop = imem_rsp_valid && (r_drop != '0);
        w_rsp_wr   = imem_rsp_valid && (r_drop == '0) && (r_pend != '0);
    end

    assign imem_req_valid = ~rst & ~flush & in_valid & w_credit;
    assign imem_req_addr  = in_pc;
    assign in_ready       = ~rst & ~flush & imem_req_ready & w_credit;
    assign out_valid      = ~rst & ~flush & r_data_ok[r_head] & (r_count != '0);
    assign out_pc         = r_pc[r_head];
    assign out_inst       = r_inst[r_head];
    assign w_fire         = imem_req_valid & imem_req_ready;
    assign w_pop          = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_head    <= '0;
            r_tail    <= '0;
            r_wptr    <= '0;
            r_count   <= '0;
            r_pend    <= '0;
            r_drop    <= '0;
            r_data_ok <= '0;
        end else if (flush) begin
            r_count   <= '0;
            r_pend    <= '0;
            r_head    <= r_tail;
            r_wptr    <= r_tail;
            r_data_ok <= '0;
            r_drop    <= r_drop + r_pend - CW'(imem_rsp_valid & w_owed);
        end else begin
            if (w_fire) begin
                r_pc[r_tail]      <= in_pc;
                r_data_ok[r_tail] <= 1'b0;
                r_tail            <= r_tail + 1'b1;
            end
            if (w_rsp_drop) begin
                r_drop <= r_drop - 1'b1;
            end
            if (w_rsp_wr) begin
                r_inst[r_wptr]    <= imem_rsp_data;
                r_data_ok[r_wptr] <= 1'b1;
                r_wptr            <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_data_ok[r_head] <= 1'b0;
                r_head            <= r_head + 1'b1;
            end
            r_count <= r_count + CW'(w_fire) - CW'(w_pop);
            r_pend  <= r_pend + CW'(w_fire) - CW'(w_rsp_wr);
        end
    end
endmodule

// File: tb/tb_ysyx_22050039_fetch_queue.sv
// Bench for the fetch queue: behavioural in-order memory plus a PC/instruction
// scoreboard, with directed timing checks around flush and reset.
module tb_ysyx_22050039_fetch_queue;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [63:0] in_pc;
    logic        in_ready;
    logic        flush;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_pc;
    logic [31:0] out_inst;

    ysyx_22050039_fetch_queue #(.XLEN(64), .DEPTH(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_pc(in_pc), .in_ready(in_ready),
        .flush(flush), .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_inst(out_inst)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] addr;
        int unsigned due;
    } mreq_t;

    mreq_t       mq[$];
    logic [63:0] sb[$];
    int unsigned cyc = 0;
    int unsigned lat = 1;
    int unsigned n_out = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    logic        stray = 1'b0;
    logic        s_ir, s_rv, s_ov;
    logic [63:0] s_pc;
    logic [31:0] s_inst;

    function automatic logic [31:0] inst_of(logic [63:0] a);
        return a[31:0] - 32'h7FFF_FBED;
    endfunction

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock cycle: memory drives its response, outputs are sampled mid-cycle,
    // the scoreboard is updated, then the edge is taken.
    task automatic step();
        mreq_t m;
        logic [63:0] e;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        if (stray) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = 32'hDEAD_BEEF;
        end else if (mq.size() != 0 && mq[0].due <= cyc) begin
            m = mq.pop_front();
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = inst_of(m.addr);
        end
        #1;
        s_ir = in_ready; s_rv = imem_req_valid; s_ov = out_valid;
        s_pc = out_pc;   s_inst = out_inst;
        if (s_rv && imem_req_ready) begin
            m.addr = imem_req_addr;
            m.due  = cyc + lat;
            mq.push_back(m);
            sb.push_back(in_pc);
        end
        if (s_ov && out_ready) begin
            n_out++;
            if (sb.size() == 0) begin
                chk("unexpected_out_pc", s_pc, 64'h0);
            end else begin
                e = sb.pop_front();
                chk("out_pc", s_pc, e);
                chk("out_inst", {32'h0, s_inst}, {32'h0, inst_of(e)});
            end
        end
        if (flush) sb.delete();
        if (rst) begin
            sb.delete();
            mq.delete();
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic drain(string tag);
        int k = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while ((sb.size() != 0 || mq.size() != 0) && k < 200) begin
            step();
            k++;
        end
        chk(tag, sb.size(), 0);
    endtask

    task automatic stream(string tag, int unsigned n, logic [63:0] base, logic rnd);
        int unsigned sent = 0;
        int unsigned n0 = n_out;
        int k = 0;
        in_pc = base;
        while (sent < n && k < 1000) begin
            in_valid = 1'b1;
            if (rnd) begin
                out_ready      = 1'($urandom_range(0, 1));
                imem_req_ready = 1'($urandom_range(0, 3) != 0);
                lat            = $urandom_range(1, 3);
            end
            step();
            if (s_ir) begin
                sent++;
                in_pc = in_pc + 64'd4;
            end
            k++;
        end
        imem_req_ready = 1'b1;
        lat = 1;
        drain({tag, "_drain"});
        chk({tag, "_count"}, n_out - n0, n);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b1; in_pc = 64'h8000_0000; flush = 1'b1;
        imem_req_ready = 1'b1; out_ready = 1'b1;
        imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        @(negedge clk);

        // reset dominates flush and handshakes
        step();
        chk("rst_in_ready", s_ir, 0);
        chk("rst_req_valid", s_rv, 0);
        chk("rst_out_valid", s_ov, 0);
        step();
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
        step();
        chk("post_rst_in_ready_hi", s_ir, 1);
        imem_req_ready = 1'b0;
        step();
        chk("post_rst_in_ready_lo", s_ir, 0);
        imem_req_ready = 1'b1;

        // single fetch, response two cycles after fire
        lat = 2; in_valid = 1'b1; in_pc = 64'h8000_0000;
        step();
        chk("f1_fire", s_rv, 1);
        in_valid = 1'b0;
        step();
        chk("f1_ov_c1", s_ov, 0);
        step();
        chk("f1_ov_rsp_cycle", s_ov, 0);
        step();
        chk("f1_ov", s_ov, 1);
        chk("f1_pc", s_pc, 64'h8000_0000);
        chk("f1_inst", {32'h0, s_inst}, 64'h413);
        drain("f1_drain");

        // fill to full with IDU stalled, pop frees credit one cycle later
        lat = 1; out_ready = 1'b0; in_valid = 1'b1; in_pc = 64'h8000_0000;
        step();
        in_pc = 64'h8000_0004;
        step();
        chk("full_second_fire", s_ir, 1);
        in_pc = 64'h8000_0008;
        step();
        chk("full_in_ready_c2", s_ir, 0);
        step();
        chk("full_in_ready_c3", s_ir, 0);
        chk("full_out_valid", s_ov, 1);
        out_ready = 1'b1;
        step();
        chk("pop_same_cycle_in_ready", s_ir, 0);
        out_ready = 1'b0;
        step();
        chk("pop_next_cycle_in_ready", s_ir, 1);
        drain("full_drain");

        // flush with two requests in flight: both responses discarded
        lat = 4; in_valid = 1'b1; in_pc = 64'h8000_0000;
        step();
        in_pc = 64'h8000_0004;
        step();
        in_valid = 1'b0; flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b1; in_pc = 64'h8000_0100; lat = 2;
        step();
        chk("fl2_in_ready_c3", s_ir, 0);
        step();
        chk("fl2_in_ready_c4", s_ir, 0);
        chk("fl2_ov_c4", s_ov, 0);
        step();
        chk("fl2_in_ready_c5", s_ir, 1);
        chk("fl2_ov_c5", s_ov, 0);
        drain("fl2_drain");

        // flush coinciding with a response, one other request still owed
        lat = 3; in_valid = 1'b1; in_pc = 64'h8000_0000;
        step();
        lat = 4; in_pc = 64'h8000_0004;
        step();
        in_valid = 1'b0;
        step();
        flush = 1'b1;
        step();
        chk("flrsp_rsp_seen", imem_rsp_valid, 1);
        flush = 1'b0; lat = 3; in_valid = 1'b1; in_pc = 64'h8000_0200;
        step();
        chk("flrsp_in_ready", s_ir, 1);
        in_valid = 1'b0;
        step();
        chk("flrsp_ov", s_ov, 0);
        drain("flrsp_drain");

        // back-to-back stream with latency 1 and IDU always ready
        stream("stream", 16, 64'h8000_0000, 1'b0);

        // reset while holding data and owing a dropped response
        out_ready = 1'b0; lat = 1; in_valid = 1'b1; in_pc = 64'h8000_0000;
        step();
        lat = 6; in_pc = 64'h8000_0004;
        step();
        in_valid = 1'b0; flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b1; in_pc = 64'h8000_0008; lat = 1;
        step();
        chk("rst2_pre_fire", s_ir, 1);
        in_valid = 1'b0; rst = 1'b1;
        step();
        rst = 1'b0; stray = 1'b1;
        step();
        chk("rst2_ov", s_ov, 0);
        chk("rst2_in_ready", s_ir, 1);
        stray = 1'b0;
        step();
        chk("rst2_ov_after_stray", s_ov, 0);
        out_ready = 1'b1;
        stream("post_rst", 4, 64'h8000_0300, 1'b0);

        // random handshakes and latencies
        stream("random", 40, 64'h8000_1000, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
